// File: rtl/seg_scan_pkg.sv
// Shared constants, code values and FSM state type for the 7-segment read-back block.
// Optional feature macro used by this slice: SEG_SCAN_DP_CAPTURE_EN (decimal-point capture).
package seg_scan_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  // Active-low segment patterns, bit order A..G (A is the MSB).
  localparam logic [6:0] SEG_0        = 7'b0000001;
  localparam logic [6:0] SEG_1        = 7'b1001111;
  localparam logic [6:0] SEG_2        = 7'b0010010;
  localparam logic [6:0] SEG_3        = 7'b0000110;
  localparam logic [6:0] SEG_4        = 7'b1001100;
  localparam logic [6:0] SEG_5        = 7'b0100100;
  localparam logic [6:0] SEG_6        = 7'b0100000;
  localparam logic [6:0] SEG_7        = 7'b0001101;
  localparam logic [6:0] SEG_8        = 7'b0000000;
  localparam logic [6:0] SEG_9        = 7'b0000100;
  localparam logic [6:0] SEG_BLANK    = 7'b1111111;
  localparam logic [6:0] SEG_ERRGLYPH = 7'b0110000;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the BCD-to-7-segment table: pattern -> 4-bit code plus unknown flag.
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code_c,
  output logic       o_unknown_c
);

  // Table lookup; anything not produced by the driver maps to the error code and is flagged.
  always_comb begin
    o_code_c    = CODE_ERR;
    o_unknown_c = 1'b0;
    case (i_seg)
      SEG_0:        o_code_c = 4'h0;
      SEG_1:        o_code_c = 4'h1;
      SEG_2:        o_code_c = 4'h2;
      SEG_3:        o_code_c = 4'h3;
      SEG_4:        o_code_c = 4'h4;
      SEG_5:        o_code_c = 4'h5;
      SEG_6:        o_code_c = 4'h6;
      SEG_7:        o_code_c = 4'h7;
      SEG_8:        o_code_c = 4'h8;
      SEG_9:        o_code_c = 4'h9;
      SEG_BLANK:    o_code_c = CODE_BLANK;
      SEG_ERRGLYPH: o_code_c = CODE_ERR;
      default:      o_unknown_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Read-back of a multiplexed active-low 7-segment bus: synchronise, debounce, decode, store per digit.
// Optional feature macro: SEG_SCAN_DP_CAPTURE_EN adds the DP output (captured decimal points).
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [7:0]              LED,
  input  logic [N_DIGITS-1:0]     AN,
  input  logic                    CLR,
  output logic [4*N_DIGITS-1:0]   DIGITS,
  output logic [N_DIGITS-1:0]     DIG_VALID,
  output logic                    UPD,
  output logic [IDX_W-1:0]        UPD_IDX,
  output logic                    FRAME,
`ifdef SEG_SCAN_DP_CAPTURE_EN
  output logic [N_DIGITS-1:0]     DP,
`endif
  output logic                    ERR
);

  localparam int unsigned S_W = N_DIGITS + 8;
  // Capture fires on the edge where the equal-sample count reaches STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

  logic [7:0]            r_led_m;
  logic [7:0]            r_led_s;
  logic [N_DIGITS-1:0]   r_an_m;
  logic [N_DIGITS-1:0]   r_an_s;
  logic [S_W-1:0]        r_s_prev;
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [4*N_DIGITS-1:0] r_digits;
  logic [N_DIGITS-1:0]   r_valid;
  logic [N_DIGITS-1:0]   r_mask;
  logic                  r_upd;
  logic [IDX_W-1:0]      r_upd_idx;
  logic                  r_frame;
  logic                  r_err;

  logic [S_W-1:0]        w_s;
  logic                  w_same;
  logic [N_DIGITS-1:0]   w_sel;
  logic                  w_onehot;
  logic [3:0]            w_code;
  logic                  w_unknown;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_cap;
  logic [N_DIGITS-1:0]   w_cap_mask;

  // Two-flop synchronisers; reset to all-ones so the bus looks like a dark display.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_led_m <= '1;
      r_led_s <= '1;
      r_an_m  <= '1;
      r_an_s  <= '1;
    end else begin
      r_led_m <= LED;
      r_led_s <= r_led_m;
      r_an_m  <= AN;
      r_an_s  <= r_an_m;
    end
  end

  assign w_s      = {r_an_s, r_led_s};
  assign w_same   = (w_s == r_s_prev);
  assign w_sel    = ~r_an_s;
  assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - N_DIGITS'(1))) == '0);

  seg_pattern_decode u_decode (
    .i_seg       (r_led_s[7:1]),
    .o_code_c    (w_code),
    .o_unknown_c (w_unknown)
  );

  // Binary index of the selected digit (only meaningful when w_onehot).
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (w_sel[i]) w_idx = IDX_W'(i);
    end
  end

  assign w_cap      = (r_state == SETTLE) && w_onehot && w_same && (r_cnt == CNT_LAST);
  assign w_cap_mask = w_cap ? w_sel : '0;

  // Debounce FSM: count consecutive identical samples while exactly one anode is active.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_s_prev <= '1;
    end else begin
      r_s_prev <= w_s;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_onehot) r_state <= SETTLE;
        end
        SETTLE: begin
          if (!w_onehot) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (!w_same) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= CAPTURED;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        CAPTURED: begin
          if (!w_same) begin
            r_cnt   <= '0;
            r_state <= w_onehot ? SETTLE : IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Capture storage, update strobe, frame tracking and sticky error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_digits  <= '0;
      r_valid   <= '0;
      r_mask    <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
      r_frame   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_upd <= w_cap;
      if (w_cap) r_upd_idx <= w_idx;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
        if (w_cap_mask[i]) begin
          r_digits[4*i +: 4] <= w_code;
          r_valid[i]         <= 1'b1;
        end
      end
      // A full mask emits FRAME next cycle and restarts, keeping any coincident capture.
      r_frame <= &r_mask;
      r_mask  <= (&r_mask) ? w_cap_mask : (r_mask | w_cap_mask);
      if (w_cap && w_unknown) r_err <= 1'b1;
      else if (CLR)           r_err <= 1'b0;
    end
  end

`ifdef SEG_SCAN_DP_CAPTURE_EN
  logic [N_DIGITS-1:0] r_dp;

  // Decimal point per digit, stored as lit = 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dp <= '0;
    end else begin
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
        if (w_cap_mask[i]) r_dp[i] <= ~r_led_s[0];
      end
    end
  end

  assign DP = r_dp;
`endif

  assign DIGITS    = r_digits;
  assign DIG_VALID = r_valid;
  assign UPD       = r_upd;
  assign UPD_IDX   = r_upd_idx;
  assign FRAME     = r_frame;
  assign ERR       = r_err;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: vector tables plus hand-written corner sequences,
// with a scoreboard queue of expected captures popped on every UPD pulse.
module tb_seg_scan_capture;
  import seg_scan_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned SC = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic [7:0]     LED;
  logic [N-1:0]   AN;
  logic           CLR;
  logic [4*N-1:0] DIGITS;
  logic [N-1:0]   DIG_VALID;
  logic           UPD;
  logic [2:0]     UPD_IDX;
  logic           FRAME;
  logic           ERR;
`ifdef SEG_SCAN_DP_CAPTURE_EN
  logic [N-1:0]   DP;
`endif

  seg_scan_capture #(.N_DIGITS(N), .STABLE_CYCLES(SC)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LED       (LED),
    .AN        (AN),
    .CLR       (CLR),
    .DIGITS    (DIGITS),
    .DIG_VALID (DIG_VALID),
    .UPD       (UPD),
    .UPD_IDX   (UPD_IDX),
    .FRAME     (FRAME),
`ifdef SEG_SCAN_DP_CAPTURE_EN
    .DP        (DP),
`endif
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] code;
  } exp_t;

  typedef struct {
    logic [N-1:0] an;
    logic [7:0]   led;
    int           n;
    bit           exp_upd;
    logic [2:0]   idx;
    logic [3:0]   code;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   upd_cnt = 0;
  int   frame_cnt = 0;
  int   last_upd_cyc = 0;
  int   last_frame_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every UPD pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (UPD === 1'b1) begin
        upd_cnt++;
        last_upd_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL upd_unexpected idx=%0d digits=%h", UPD_IDX, DIGITS);
        end else begin
          mon_e = sb.pop_front();
          check("upd_idx", 32'(UPD_IDX), 32'(mon_e.idx));
          check("upd_code", 32'(DIGITS[4*mon_e.idx +: 4]), 32'(mon_e.code));
        end
      end
      if (FRAME === 1'b1) begin
        frame_cnt++;
        last_frame_cyc = cyc;
      end
    end
  end

  task automatic hold(input logic [N-1:0] an, input logic [7:0] led, input int n);
    @(negedge CLK);
    AN  = an;
    LED = led;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    if (v.exp_upd) begin
      e.idx  = v.idx;
      e.code = v.code;
      sb.push_back(e);
    end
    hold(v.an, v.led, v.n);
  endtask

  vec_t scan[5];
  exp_t e0;
  int   t0;
  int   u0;

  initial begin
    // Four-digit scan 1,2,3,4 followed by a dark bus.
    scan[0] = '{4'b1110, {SEG_1, 1'b1}, 8, 1'b1, 3'd0, 4'h1};
    scan[1] = '{4'b1101, {SEG_2, 1'b1}, 8, 1'b1, 3'd1, 4'h2};
    scan[2] = '{4'b1011, {SEG_3, 1'b1}, 8, 1'b1, 3'd2, 4'h3};
    scan[3] = '{4'b0111, {SEG_4, 1'b1}, 8, 1'b1, 3'd3, 4'h4};
    scan[4] = '{4'b1111, {SEG_BLANK, 1'b1}, 6, 1'b0, 3'd0, 4'h0};

    RST = 1'b1;
    CLR = 1'b0;
    LED = 8'hFF;
    AN  = '1;
    repeat (2) @(negedge CLK);
    check("rst_digits", 32'(DIGITS), 32'h0);
    check("rst_valid", 32'(DIG_VALID), 32'h0);
    check("rst_upd", 32'(UPD), 32'h0);
    check("rst_idx", 32'(UPD_IDX), 32'h0);
    check("rst_frame", 32'(FRAME), 32'h0);
    check("rst_err", 32'(ERR), 32'h0);
`ifdef SEG_SCAN_DP_CAPTURE_EN
    check("rst_dp", 32'(DP), 32'h0);
`endif
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Single digit held: one capture, STABLE_CYCLES+1 edges after the first sampling edge.
    @(negedge CLK);
    AN  = 4'b1110;
    LED = {SEG_3, 1'b1};
    t0  = cyc;
    e0.idx = 3'd0; e0.code = 4'h3; sb.push_back(e0);
    repeat (9) @(negedge CLK);
    check("t1_latency", 32'(last_upd_cyc - t0), 32'(SC + 2));
    check("t1_upd_cnt", 32'(upd_cnt), 32'd1);
    check("t1_digit0", 32'(DIGITS[3:0]), 32'h3);
    check("t1_valid", 32'(DIG_VALID), 32'b0001);
    check("t1_err", 32'(ERR), 32'h0);
    hold(4'b1111, 8'hFF, 4);

    // Scan table: four captures and exactly one FRAME right after the last one.
    for (int i = 0; i < 5; i++) run_vec(scan[i]);
    check("scan_upd_cnt", 32'(upd_cnt), 32'd5);
    check("scan_digits", 32'(DIGITS), 32'h4321);
    check("scan_valid", 32'(DIG_VALID), 32'b1111);
    check("scan_frame_cnt", 32'(frame_cnt), 32'd1);
    check("scan_frame_time", 32'(last_frame_cyc), 32'(last_upd_cyc + 1));

    // Bouncing pattern never settles; then a steady 5 is captured on digit 1.
    u0 = upd_cnt;
    for (int i = 0; i < 6; i++) hold(4'b1101, (i % 2 == 0) ? {SEG_5, 1'b1} : {SEG_2, 1'b1}, 2);
    check("bounce_no_upd", 32'(upd_cnt), 32'(u0));
    e0.idx = 3'd1; e0.code = 4'h5; sb.push_back(e0);
    hold(4'b1101, {SEG_5, 1'b1}, 8);
    check("bounce_digit1", 32'(DIGITS[7:4]), 32'h5);

    // Two anodes low: ghosting is ignored entirely.
    u0 = upd_cnt;
    hold(4'b1100, {SEG_8, 1'b1}, 20);
    check("ghost_no_upd", 32'(upd_cnt), 32'(u0));
    check("ghost_state", 32'(dut.r_state), 32'(IDLE));
    check("ghost_digits", 32'(DIGITS), 32'h4351);
    check("ghost_err", 32'(ERR), 32'h0);

    // Unknown pattern on digit 2 sets ERR; CLR clears it.
    e0.idx = 3'd2; e0.code = CODE_ERR; sb.push_back(e0);
    hold(4'b1011, 8'b1010101_1, 8);
    check("unk_err_set", 32'(ERR), 32'h1);
    check("unk_digit2", 32'(DIGITS[11:8]), 32'hE);
    @(negedge CLK); CLR = 1'b1;
    @(negedge CLK); CLR = 1'b0;
    check("unk_err_clr", 32'(ERR), 32'h0);
    hold(4'b1111, 8'hFF, 4);

    // CLR coincident with the unknown capture: set wins.
    @(negedge CLK);
    AN  = 4'b1011;
    LED = 8'b1010101_1;
    e0.idx = 3'd2; e0.code = CODE_ERR; sb.push_back(e0);
    repeat (5) @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    check("unk_set_wins", 32'(ERR), 32'h1);
    repeat (2) @(negedge CLK);
    check("unk_sticky", 32'(ERR), 32'h1);
    hold(4'b1111, 8'hFF, 4);

    // Restore 4321 then reset asynchronously while digit 0 is settling.
    for (int i = 0; i < 5; i++) run_vec(scan[i]);
    check("pre_rst_digits", 32'(DIGITS), 32'h4321);
    @(negedge CLK);
    AN  = 4'b1110;
    LED = {SEG_7, 1'b1};
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("arst_digits", 32'(DIGITS), 32'h0);
    check("arst_valid", 32'(DIG_VALID), 32'h0);
    check("arst_idx", 32'(UPD_IDX), 32'h0);
    check("arst_err", 32'(ERR), 32'h0);
    check("arst_frame", 32'(FRAME), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    t0  = cyc;
    e0.idx = 3'd0; e0.code = 4'h7; sb.push_back(e0);
    repeat (9) @(negedge CLK);
    check("post_rst_latency", 32'(last_upd_cyc - t0), 32'(SC + 2));
    check("post_rst_digits", 32'(DIGITS), 32'h0007);
    check("post_rst_valid", 32'(DIG_VALID), 32'b0001);

`ifdef SEG_SCAN_DP_CAPTURE_EN
    // Lit decimal point on digit 1.
    e0.idx = 3'd1; e0.code = 4'h8; sb.push_back(e0);
    hold(4'b1101, {SEG_8, 1'b0}, 8);
    check("dp_capture", 32'(DP), 32'b0010);
`endif

    hold(4'b1111, 8'hFF, 4);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
